// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: sequencer states,
// opcode constants and IR field positions.
// Optional feature macro: CTRL_MULDIV_EN (adds the T6 state for mul/div).
package cpu_pkg;

    // IR field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
`ifdef CTRL_MULDIV_EN
        ST_T6     = 4'd7,
`endif
        ST_HALTED = 4'd8
    } state_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Single-result ALU operations occupy one contiguous opcode range
    function automatic logic is_alu_op(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_ROL);
    endfunction

    function automatic logic is_muldiv_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Datapath control bundle between the sequencer (master) and the datapath (slave).
interface control_sequencer_if #(
    parameter int IR_W = 32,
    parameter int OP_W = 5
);
    logic            start;
    logic            mem_ready;
    logic [IR_W-1:0] ir;
    logic [15:0]     Rin;
    logic [15:0]     Rout;
    logic            PCin;
    logic            PCout;
    logic            MARin;
    logic            MDRin;
    logic            MDRout;
    logic            MDR_read;
    logic            IRin;
    logic            Yin;
    logic            Zlowin;
    logic            Zhighin;
    logic            Zlowout;
    logic            Zhighout;
    logic            HIin;
    logic            LOin;
    logic            pcInc;
    logic [OP_W-1:0] op_code;
    logic            halted;
    logic            illegal;

    modport master (
        input  start, mem_ready, ir,
        output Rin, Rout, PCin, PCout, MARin, MDRin, MDRout, MDR_read, IRin,
               Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, pcInc,
               op_code, halted, illegal
    );

    modport slave (
        output start, mem_ready, ir,
        input  Rin, Rout, PCin, PCout, MARin, MDRin, MDRout, MDR_read, IRin,
               Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, pcInc,
               op_code, halted, illegal
    );
endinterface

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot register select decoder with enable.
module reg_select_decoder (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);
    // At most one bit set, none when disabled
    always_comb begin
        onehot = 16'h0000;
        if (en) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = 16'h0000;
        end
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus CPU datapath: fetch T0-T2,
// execute T3-T6. Strobes are Moore-decoded from the state and IR, so an
// asynchronous reset clears every strobe immediately.
// Optional feature macro: CTRL_MULDIV_EN (mul/div via T5->T6 with HI/LO writes).
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int IR_W = 32,
    parameter int OP_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    control_sequencer_if.master bus
);
    state_e          state_r;
    state_e          next_state_s;
    logic            illegal_r;

    logic [OP_W-1:0] opcode_s;
    logic [3:0]      ra_s;
    logic [3:0]      rb_s;
    logic [3:0]      rc_s;
    logic            is_exec_s;
    logic            unused_ir_s;

    logic            rin_en_s;
    logic            rout_en_s;
    logic [3:0]      rout_sel_s;
    logic [15:0]     rin_s;
    logic [15:0]     rout_s;
    logic            pcin_s, pcout_s, marin_s, mdrin_s, mdrout_s, mdr_read_s;
    logic            irin_s, yin_s, zlowin_s, zlowout_s, pcinc_s, halted_s;
    logic [OP_W-1:0] op_code_s;

    assign opcode_s    = bus.ir[IR_W-1 -: OP_W];
    assign ra_s        = bus.ir[RA_HI:RA_LO];
    assign rb_s        = bus.ir[RB_HI:RB_LO];
    assign rc_s        = bus.ir[RC_HI:RC_LO];
    assign unused_ir_s = ^bus.ir[RC_LO-1:0];

`ifdef CTRL_MULDIV_EN
    logic muldiv_s;
    logic zhighin_s, zhighout_s, hiin_s, loin_s;
    assign muldiv_s  = is_muldiv_op(opcode_s);
    assign is_exec_s = is_alu_op(opcode_s) || muldiv_s;
`else
    assign is_exec_s = is_alu_op(opcode_s);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Sticky illegal flag: set on a bad decode, cleared when restarting from HALTED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if ((state_r == ST_T3) && !is_exec_s &&
                     (opcode_s != OP_NOP) && (opcode_s != OP_HALT)) begin
            illegal_r <= 1'b1;
        end else if ((state_r == ST_HALTED) && bus.start) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:   next_state_s = bus.start ? ST_T0 : ST_IDLE;
            ST_T0:     next_state_s = ST_T1;
            ST_T1:     next_state_s = bus.mem_ready ? ST_T2 : ST_T1;
            ST_T2:     next_state_s = ST_T3;
            ST_T3: begin
                if (is_exec_s) begin
                    next_state_s = ST_T4;
                end else if (opcode_s == OP_NOP) begin
                    next_state_s = ST_T0;
                end else begin
                    next_state_s = ST_HALTED;
                end
            end
            ST_T4:     next_state_s = ST_T5;
`ifdef CTRL_MULDIV_EN
            ST_T5:     next_state_s = muldiv_s ? ST_T6 : ST_T0;
            ST_T6:     next_state_s = ST_T0;
`else
            ST_T5:     next_state_s = ST_T0;
`endif
            ST_HALTED: next_state_s = bus.start ? ST_T0 : ST_HALTED;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Moore strobe decode from state and IR
    always_comb begin
        rin_en_s   = 1'b0;
        rout_en_s  = 1'b0;
        rout_sel_s = rb_s;
        pcin_s     = 1'b0;
        pcout_s    = 1'b0;
        marin_s    = 1'b0;
        mdrin_s    = 1'b0;
        mdrout_s   = 1'b0;
        mdr_read_s = 1'b0;
        irin_s     = 1'b0;
        yin_s      = 1'b0;
        zlowin_s   = 1'b0;
        zlowout_s  = 1'b0;
        pcinc_s    = 1'b0;
        halted_s   = 1'b0;
        op_code_s  = '0;
`ifdef CTRL_MULDIV_EN
        zhighin_s  = 1'b0;
        zhighout_s = 1'b0;
        hiin_s     = 1'b0;
        loin_s     = 1'b0;
`endif
        case (state_r)
            ST_T0: begin
                pcout_s  = 1'b1;
                marin_s  = 1'b1;
                pcinc_s  = 1'b1;
                zlowin_s = 1'b1;
            end
            ST_T1: begin
                zlowout_s  = 1'b1;
                pcin_s     = 1'b1;
                mdr_read_s = 1'b1;
                mdrin_s    = 1'b1;
            end
            ST_T2: begin
                mdrout_s = 1'b1;
                irin_s   = 1'b1;
            end
            ST_T3: begin
                if (is_exec_s) begin
                    rout_en_s = 1'b1;
                    yin_s     = 1'b1;
                end else begin
                    rout_en_s = 1'b0;
                end
            end
            ST_T4: begin
                rout_en_s  = 1'b1;
                rout_sel_s = rc_s;
                op_code_s  = opcode_s;
                zlowin_s   = 1'b1;
`ifdef CTRL_MULDIV_EN
                zhighin_s  = muldiv_s;
`endif
            end
            ST_T5: begin
                zlowout_s = 1'b1;
`ifdef CTRL_MULDIV_EN
                if (muldiv_s) begin
                    loin_s = 1'b1;
                end else begin
                    rin_en_s = 1'b1;
                end
`else
                rin_en_s = 1'b1;
`endif
            end
`ifdef CTRL_MULDIV_EN
            ST_T6: begin
                zhighout_s = 1'b1;
                hiin_s     = 1'b1;
            end
`endif
            ST_HALTED: halted_s = 1'b1;
            default:   halted_s = 1'b0;
        endcase
    end

    reg_select_decoder u_rin_dec (
        .en     (rin_en_s),
        .sel    (ra_s),
        .onehot (rin_s)
    );

    reg_select_decoder u_rout_dec (
        .en     (rout_en_s),
        .sel    (rout_sel_s),
        .onehot (rout_s)
    );

    assign bus.Rin      = rin_s;
    assign bus.Rout     = rout_s;
    assign bus.PCin     = pcin_s;
    assign bus.PCout    = pcout_s;
    assign bus.MARin    = marin_s;
    assign bus.MDRin    = mdrin_s;
    assign bus.MDRout   = mdrout_s;
    assign bus.MDR_read = mdr_read_s;
    assign bus.IRin     = irin_s;
    assign bus.Yin      = yin_s;
    assign bus.Zlowin   = zlowin_s;
    assign bus.Zlowout  = zlowout_s;
    assign bus.pcInc    = pcinc_s;
    assign bus.op_code  = op_code_s;
    assign bus.halted   = halted_s;
    assign bus.illegal  = illegal_r;
`ifdef CTRL_MULDIV_EN
    assign bus.Zhighin  = zhighin_s;
    assign bus.Zhighout = zhighout_s;
    assign bus.HIin     = hiin_s;
    assign bus.LOin     = loin_s;
`else
    assign bus.Zhighin  = 1'b0;
    assign bus.Zhighout = 1'b0;
    assign bus.HIin     = 1'b0;
    assign bus.LOin     = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
// Mul/div expectations follow CTRL_MULDIV_EN.
module tb_control_sequencer;

    localparam logic [14:0] S_PCIN   = 15'h4000;
    localparam logic [14:0] S_PCOUT  = 15'h2000;
    localparam logic [14:0] S_MARIN  = 15'h1000;
    localparam logic [14:0] S_MDRIN  = 15'h0800;
    localparam logic [14:0] S_MDROUT = 15'h0400;
    localparam logic [14:0] S_MDRRD  = 15'h0200;
    localparam logic [14:0] S_IRIN   = 15'h0100;
    localparam logic [14:0] S_YIN    = 15'h0080;
    localparam logic [14:0] S_ZLOIN  = 15'h0040;
    localparam logic [14:0] S_ZHIIN  = 15'h0020;
    localparam logic [14:0] S_ZLOOUT = 15'h0010;
    localparam logic [14:0] S_ZHIOUT = 15'h0008;
    localparam logic [14:0] S_HIIN   = 15'h0004;
    localparam logic [14:0] S_LOIN   = 15'h0002;
    localparam logic [14:0] S_PCINC  = 15'h0001;
    localparam logic [14:0] S_T0 = S_PCOUT | S_MARIN | S_PCINC | S_ZLOIN;
    localparam logic [14:0] S_T1 = S_ZLOOUT | S_PCIN | S_MDRRD | S_MDRIN;
    localparam logic [14:0] S_T2 = S_MDROUT | S_IRIN;

    localparam logic [31:0] IR_AND  = 32'h28918000;
    localparam logic [31:0] IR_MUL  = 32'h78228000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    control_sequencer_if #(.IR_W(32), .OP_W(5)) bus ();

    control_sequencer #(.IR_W(32), .OP_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [53:0] mk(input logic [15:0] rin, input logic [15:0] rout,
                                       input logic [14:0] s, input logic [4:0] op,
                                       input logic h, input logic il);
        return {rin, rout, s, op, h, il};
    endfunction

    function automatic logic [53:0] obs();
        return {bus.Rin, bus.Rout, bus.PCin, bus.PCout, bus.MARin, bus.MDRin,
                bus.MDRout, bus.MDR_read, bus.IRin, bus.Yin, bus.Zlowin, bus.Zhighin,
                bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin, bus.pcInc,
                bus.op_code, bus.halted, bus.illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic launch(input logic [31:0] instr);
        do_reset();
        bus.ir    = instr;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (obs() !== 54'd0) begin
            miscompares++;
            $display("FAIL reset_hold: got %h expected %h", obs(), 54'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs() !== 54'd0) begin
                miscompares++;
                $display("FAIL idle_no_start cyc%0d: got %h expected %h", i, obs(), 54'd0);
            end
        end
    endtask

    task automatic test_alu();
        logic [53:0] exp [0:6];
        exp[0] = mk(16'h0000, 16'h0000, S_T0, 5'd0, 1'b0, 1'b0);
        exp[1] = mk(16'h0000, 16'h0000, S_T1, 5'd0, 1'b0, 1'b0);
        exp[2] = mk(16'h0000, 16'h0000, S_T2, 5'd0, 1'b0, 1'b0);
        exp[3] = mk(16'h0000, 16'h0004, S_YIN, 5'd0, 1'b0, 1'b0);
        exp[4] = mk(16'h0000, 16'h0008, S_ZLOIN, 5'b00101, 1'b0, 1'b0);
        exp[5] = mk(16'h0002, 16'h0000, S_ZLOOUT, 5'd0, 1'b0, 1'b0);
        exp[6] = mk(16'h0000, 16'h0000, S_T0, 5'd0, 1'b0, 1'b0);
        launch(IR_AND);
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (obs() !== exp[i]) begin
                miscompares++;
                $display("FAIL alu_and cyc%0d: got %h expected %h", i, obs(), exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        logic [53:0] e_t1;
        logic [53:0] e_t0;
        logic [53:0] e_t2;
        e_t0 = mk(16'h0000, 16'h0000, S_T0, 5'd0, 1'b0, 1'b0);
        e_t1 = mk(16'h0000, 16'h0000, S_T1, 5'd0, 1'b0, 1'b0);
        e_t2 = mk(16'h0000, 16'h0000, S_T2, 5'd0, 1'b0, 1'b0);
        do_reset();
        bus.ir        = IR_AND;
        bus.mem_ready = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        vectors++;
        if (obs() !== e_t0) begin
            miscompares++;
            $display("FAIL wait_t0: got %h expected %h", obs(), e_t0);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (obs() !== e_t1) begin
                miscompares++;
                $display("FAIL wait_t1 cyc%0d: got %h expected %h", i, obs(), e_t1);
            end
            if (i == 3) bus.mem_ready = 1'b1;
            tick();
        end
        vectors++;
        if (obs() !== e_t2) begin
            miscompares++;
            $display("FAIL wait_t2: got %h expected %h", obs(), e_t2);
        end
    endtask

    task automatic test_mul();
`ifdef CTRL_MULDIV_EN
        localparam int N = 8;
`else
        localparam int N = 6;
`endif
        logic [53:0] exp [0:N-1];
        exp[0] = mk(16'h0000, 16'h0000, S_T0, 5'd0, 1'b0, 1'b0);
        exp[1] = mk(16'h0000, 16'h0000, S_T1, 5'd0, 1'b0, 1'b0);
        exp[2] = mk(16'h0000, 16'h0000, S_T2, 5'd0, 1'b0, 1'b0);
`ifdef CTRL_MULDIV_EN
        exp[3] = mk(16'h0000, 16'h0010, S_YIN, 5'd0, 1'b0, 1'b0);
        exp[4] = mk(16'h0000, 16'h0020, S_ZLOIN | S_ZHIIN, 5'b01111, 1'b0, 1'b0);
        exp[5] = mk(16'h0000, 16'h0000, S_ZLOOUT | S_LOIN, 5'd0, 1'b0, 1'b0);
        exp[6] = mk(16'h0000, 16'h0000, S_ZHIOUT | S_HIIN, 5'd0, 1'b0, 1'b0);
        exp[7] = mk(16'h0000, 16'h0000, S_T0, 5'd0, 1'b0, 1'b0);
`else
        exp[3] = mk(16'h0000, 16'h0000, 15'h0000, 5'd0, 1'b0, 1'b0);
        exp[4] = mk(16'h0000, 16'h0000, 15'h0000, 5'd0, 1'b1, 1'b1);
        exp[5] = mk(16'h0000, 16'h0000, 15'h0000, 5'd0, 1'b1, 1'b1);
`endif
        launch(IR_MUL);
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (obs() !== exp[i]) begin
                miscompares++;
                $display("FAIL mul cyc%0d: got %h expected %h", i, obs(), exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_halt_and_illegal(input logic [31:0] instr, input logic il,
                                         input string tag);
        logic [53:0] exp [0:6];
        exp[0] = mk(16'h0000, 16'h0000, S_T0, 5'd0, 1'b0, 1'b0);
        exp[1] = mk(16'h0000, 16'h0000, S_T1, 5'd0, 1'b0, 1'b0);
        exp[2] = mk(16'h0000, 16'h0000, S_T2, 5'd0, 1'b0, 1'b0);
        exp[3] = mk(16'h0000, 16'h0000, 15'h0000, 5'd0, 1'b0, 1'b0);
        exp[4] = mk(16'h0000, 16'h0000, 15'h0000, 5'd0, 1'b1, il);
        exp[5] = mk(16'h0000, 16'h0000, 15'h0000, 5'd0, 1'b1, il);
        exp[6] = mk(16'h0000, 16'h0000, S_T0, 5'd0, 1'b0, 1'b0);
        launch(instr);
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (obs() !== exp[i]) begin
                miscompares++;
                $display("FAIL %s cyc%0d: got %h expected %h", tag, i, obs(), exp[i]);
            end
            if (i == 5) begin
                bus.ir    = IR_NOP;
                bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
        end
    endtask

    task automatic test_nop_start_held();
        logic [53:0] exp [0:5];
        exp[0] = mk(16'h0000, 16'h0000, S_T0, 5'd0, 1'b0, 1'b0);
        exp[1] = mk(16'h0000, 16'h0000, S_T1, 5'd0, 1'b0, 1'b0);
        exp[2] = mk(16'h0000, 16'h0000, S_T2, 5'd0, 1'b0, 1'b0);
        exp[3] = mk(16'h0000, 16'h0000, 15'h0000, 5'd0, 1'b0, 1'b0);
        exp[4] = mk(16'h0000, 16'h0000, S_T0, 5'd0, 1'b0, 1'b0);
        exp[5] = mk(16'h0000, 16'h0000, S_T1, 5'd0, 1'b0, 1'b0);
        launch(IR_NOP);
        bus.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (obs() !== exp[i]) begin
                miscompares++;
                $display("FAIL nop_start_held cyc%0d: got %h expected %h", i, obs(), exp[i]);
            end
            tick();
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset_mid_t4();
        logic [53:0] e_t4;
        e_t4 = mk(16'h0000, 16'h0008, S_ZLOIN, 5'b00101, 1'b0, 1'b0);
        launch(IR_AND);
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (obs() !== e_t4) begin
            miscompares++;
            $display("FAIL mid_t4_before: got %h expected %h", obs(), e_t4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs() !== 54'd0) begin
            miscompares++;
            $display("FAIL mid_t4_async: got %h expected %h", obs(), 54'd0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (obs() !== 54'd0) begin
            miscompares++;
            $display("FAIL mid_t4_idle: got %h expected %h", obs(), 54'd0);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.ir        = 32'h00000000;
        test_reset();
        test_alu();
        test_mem_wait();
        test_mul();
        test_halt_and_illegal(IR_HALT, 1'b0, "halt");
        test_halt_and_illegal(IR_BAD, 1'b1, "illegal");
        test_nop_start_held();
        test_reset_mid_t4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
